t05_hist_reader: RTL and testbench

Read-back side of the byte histogram. After the histogram asserts eof, this block sweeps the 256 count words that t05_histogram wrote to SRAM. It emits each non-zero bin as a (char, count) pair over a valid/ready stream to the Huffman tree builder. With CLEAR_ON_READ set, it zeroes each visited non-zero bin so the SRAM is ready for the next file. It also cross-checks the summed counts against the histogram's total.

---
 rtl/t05_pkg.sv | 18 +
 rtl/t05_hist_reader_if.sv | 22 ++
 rtl/t05_hist_reader.sv | 140 ++++++++++++++
 tb/tb_t05_hist_reader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t05_pkg.sv
// Shared definitions for the t05 histogram pipeline: reader state encoding,
// default sizes and the EOF character the histogram also uses.
package t05_pkg;

   localparam int         NUM_BINS_DEF = 256;
   localparam int         CNT_W_DEF    = 32;
   localparam logic [7:0] EOF_CHAR     = 8'h1A;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CLR,
      ST_EMIT,
      ST_NEXT,
      ST_DONE
   } t05_hist_rd_state_t;

endpackage

// File: rtl/t05_hist_reader_if.sv
// Single-request SRAM port between the histogram reader (master) and the
// count memory (slave); every request is held until a one-cycle ack.
interface t05_hist_reader_if #(
   parameter int CNT_W = 32
);
   logic [7:0]       addr;
   logic             rd_en;
   logic             wr_en;
   logic [CNT_W-1:0] wdata;
   logic [CNT_W-1:0] rdata;
   logic             ack;

   modport master (
      output addr, rd_en, wr_en, wdata,
      input  rdata, ack
   );

   modport slave (
      input  addr, rd_en, wr_en, wdata,
      output rdata, ack
   );
endinterface

// File: rtl/t05_hist_reader.sv
// Sweeps the histogram count SRAM after eof, streams non-zero bins as
// (char, count) pairs, optionally clears them, and checks the summed total.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start
// RD      | read request at addr held until ack; count captured on ack
// CLR     | write-0 request at addr held until ack (CLEAR_ON_READ only)
// EMIT    | pair presented on the output stream until out_ready
// NEXT    | single cycle: finish at the last bin, else advance addr
// DONE    | sweep finished; done/mismatch held until next start
module t05_hist_reader
   import t05_pkg::*;
#(
   parameter int NUM_BINS      = NUM_BINS_DEF,
   parameter int CNT_W         = CNT_W_DEF,
   parameter bit CLEAR_ON_READ = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CNT_W-1:0]     total_in,
   t05_hist_reader_if.master    sram,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [7:0]           out_char,
   output logic [CNT_W-1:0]     out_count,
   output logic [8:0]           nonzero_bins,
   output logic [CNT_W-1:0]     sum,
   output logic                 busy,
   output logic                 done,
   output logic                 mismatch
);

   localparam logic [7:0] LAST_ADDR = 8'(NUM_BINS - 1);

   t05_hist_rd_state_t state;
   logic [7:0]         addr_q;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   total_q;
   logic               sat_q;
   logic               rd_en_q;
   logic               wr_en_q;
   logic [CNT_W:0]     sum_ext;

   // One spare bit catches the carry out so the running sum can saturate.
   assign sum_ext = {1'b0, sum} + {1'b0, count_q};

   assign sram.addr  = addr_q;
   assign sram.rd_en = rd_en_q;
   assign sram.wr_en = wr_en_q;
   assign sram.wdata = '0;
   assign out_char   = addr_q;
   assign out_count  = count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         addr_q       <= '0;
         count_q      <= '0;
         total_q      <= '0;
         sat_q        <= 1'b0;
         rd_en_q      <= 1'b0;
         wr_en_q      <= 1'b0;
         out_valid    <= 1'b0;
         nonzero_bins <= '0;
         sum          <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         mismatch     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  total_q      <= total_in;
                  addr_q       <= '0;
                  sum          <= '0;
                  sat_q        <= 1'b0;
                  nonzero_bins <= '0;
                  mismatch     <= 1'b0;
                  done         <= 1'b0;
                  busy         <= 1'b1;
                  rd_en_q      <= 1'b1;
                  state        <= ST_RD;
               end
            end
            ST_RD: begin
               if (sram.ack) begin
                  count_q <= sram.rdata;
                  rd_en_q <= 1'b0;
                  if (sram.rdata == '0) begin
                     state <= ST_NEXT;
                  end else if (CLEAR_ON_READ) begin
                     wr_en_q <= 1'b1;
                     state   <= ST_CLR;
                  end else begin
                     out_valid <= 1'b1;
                     state     <= ST_EMIT;
                  end
               end
            end
            ST_CLR: begin
               if (sram.ack) begin
                  wr_en_q   <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (out_ready) begin
                  out_valid    <= 1'b0;
                  nonzero_bins <= nonzero_bins + 9'd1;
                  if (sum_ext[CNT_W]) begin
                     sum   <= '1;
                     sat_q <= 1'b1;
                  end else begin
                     sum <= sum_ext[CNT_W-1:0];
                  end
                  state <= ST_NEXT;
               end
            end
            ST_NEXT: begin
               // Compare before incrementing so a full 256-bin sweep ends at 0xFF.
               if (addr_q == LAST_ADDR) begin
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  mismatch <= (sum != total_q) || sat_q;
                  state    <= ST_DONE;
               end else begin
                  addr_q  <= addr_q + 8'd1;
                  rd_en_q <= 1'b1;
                  state   <= ST_RD;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_t05_hist_reader.sv
// Directed bench for t05_hist_reader: one clearing instance driven from a
// vector table plus a non-clearing instance with random SRAM ack latency.
module tb_t05_hist_reader;
   import t05_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start_a, start_b;
   logic [31:0] total_a, total_b;
   logic        ready_a, ready_b;

   logic        valid_a, busy_a, done_a, mm_a;
   logic [7:0]  char_a;
   logic [31:0] count_a, sum_a;
   logic [8:0]  nz_a;
   logic        valid_b, busy_b, done_b, mm_b;
   logic [7:0]  char_b;
   logic [31:0] count_b, sum_b;
   logic [8:0]  nz_b;

   t05_hist_reader_if #(.CNT_W(32)) sram_a ();
   t05_hist_reader_if #(.CNT_W(32)) sram_b ();

   t05_hist_reader #(.NUM_BINS(256), .CNT_W(32), .CLEAR_ON_READ(1'b1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .total_in(total_a), .sram(sram_a),
      .out_valid(valid_a), .out_ready(ready_a), .out_char(char_a), .out_count(count_a),
      .nonzero_bins(nz_a), .sum(sum_a), .busy(busy_a), .done(done_a), .mismatch(mm_a));

   t05_hist_reader #(.NUM_BINS(256), .CNT_W(32), .CLEAR_ON_READ(1'b0)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .total_in(total_b), .sram(sram_b),
      .out_valid(valid_b), .out_ready(ready_b), .out_char(char_b), .out_count(count_b),
      .nonzero_bins(nz_b), .sum(sum_b), .busy(busy_b), .done(done_b), .mismatch(mm_b));

   // SRAM models: instance a acks in the first request cycle, b after 1..4 cycles.
   logic [31:0] mem_a [256];
   logic [31:0] pre_a [256];
   logic [31:0] mem_b [256];
   logic [31:0] pre_b [256];
   logic        load_a = 1'b0, load_b = 1'b0;
   int          wcnt_b = 0, lat_b = 1;

   assign sram_a.ack   = sram_a.rd_en || sram_a.wr_en;
   assign sram_a.rdata = mem_a[sram_a.addr];
   assign sram_b.ack   = (sram_b.rd_en || sram_b.wr_en) && (wcnt_b == lat_b - 1);
   assign sram_b.rdata = mem_b[sram_b.addr];

   always @(posedge clk) begin
      if (load_a) begin
         for (int i = 0; i < 256; i++) mem_a[i] <= pre_a[i];
      end else if (sram_a.ack && sram_a.wr_en) begin
         mem_a[sram_a.addr] <= sram_a.wdata;
      end
      if (load_b) begin
         for (int i = 0; i < 256; i++) mem_b[i] <= pre_b[i];
      end else if (sram_b.ack && sram_b.wr_en) begin
         mem_b[sram_b.addr] <= sram_b.wdata;
      end
      if (sram_b.ack) begin
         wcnt_b <= 0;
         lat_b  <= int'($urandom_range(1, 4));
      end else if (sram_b.rd_en || sram_b.wr_en) begin
         wcnt_b <= wcnt_b + 1;
      end
   end

   // Downstream for a: optional stall of N cycles per pair, optional hold at 0x41.
   int stall   = 0;
   bit block41 = 1'b0;
   initial begin
      int vcnt;
      vcnt    = 0;
      ready_a = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!valid_a) begin
            vcnt    = 0;
            ready_a = (stall == 0) && !block41;
         end else if (block41 && char_a == 8'h41) begin
            ready_a = 1'b0;
         end else begin
            ready_a = (vcnt >= stall);
            vcnt++;
         end
      end
   end

   // Monitors: collect pairs, watch stability under backpressure and SRAM protocol.
   logic [39:0] got_a[$];
   logic [39:0] got_b[$];
   int          stab_viol = 0, proto_a = 0, proto_b = 0;
   logic        pend_a = 1'b0, prd_b = 1'b0;
   logic [7:0]  pc_a, pa_b;
   logic [31:0] pn_a;

   always @(negedge clk) begin
      if (valid_a && ready_a) got_a.push_back({char_a, count_a});
      if (valid_b && ready_b) got_b.push_back({char_b, count_b});
      if (pend_a && !rst && (!valid_a || char_a != pc_a || count_a != pn_a))
         stab_viol <= stab_viol + 1;
      pend_a <= valid_a && !ready_a && !rst;
      pc_a   <= char_a;
      pn_a   <= count_a;
      if (sram_a.rd_en && sram_a.wr_en) proto_a <= proto_a + 1;
      if (sram_b.wr_en || (prd_b && !rst && !(sram_b.rd_en && sram_b.addr == pa_b)))
         proto_b <= proto_b + 1;
      prd_b <= sram_b.rd_en && !sram_b.ack;
      pa_b  <= sram_b.addr;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic kick(input bit which, input logic [31:0] tot);
      if (which) begin start_b = 1'b1; total_b = tot; end
      else       begin start_a = 1'b1; total_a = tot; end
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_done(input bit which, output int cyc);
      cyc = 0;
      while (!(which ? done_b : done_a) && cyc < 5000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk(which ? "done_b" : "done_a", which ? done_b : done_a, 1'b1);
   endtask

   typedef struct {
      logic [7:0]  c0; logic [31:0] n0;
      logic [7:0]  c1; logic [31:0] n1;
      logic [7:0]  c2; logic [31:0] n2;
      logic [31:0] total;
      int          stall;
      int          exp_nz;
      logic [31:0] exp_sum;
      logic        exp_mm;
      int          exp_cyc;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [39:0] expq[$];
      int          cyc;
      int          snap;

      vecs[0] = '{8'h00, 32'd0, 8'h00, 32'd0, 8'h00, 32'd0, 32'd0, 0, 0, 32'd0, 1'b0, 512};
      vecs[1] = '{8'h00, 32'd10, 8'h41, 32'd3, 8'hFF, 32'd1, 32'd14, 0, 3, 32'd14, 1'b0, 518};
      vecs[2] = '{8'h00, 32'd10, 8'h41, 32'd3, 8'hFF, 32'd1, 32'd14, 5, 3, 32'd14, 1'b0, 533};
      vecs[3] = '{8'h00, 32'd10, 8'h41, 32'd3, 8'hFF, 32'd1, 32'd15, 0, 3, 32'd14, 1'b1, 518};
      vecs[4] = '{8'h01, 32'hFFFF_FFFF, 8'h02, 32'd2, 8'h03, 32'd0, 32'hFFFF_FFFF, 0, 2,
                  32'hFFFF_FFFF, 1'b1, 516};

      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; total_a = '0; total_b = '0; ready_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", valid_a, 1'b0);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_done", done_a, 1'b0);
      chk("rst_mismatch", mm_a, 1'b0);
      chk("rst_nz", nz_a, 9'd0);
      chk("rst_sum", sum_a, 32'd0);
      chk("rst_strobes", {sram_a.rd_en, sram_a.wr_en, sram_a.addr}, 10'd0);
      chk("rst_pair", {char_a, count_a}, 40'd0);
      rst = 1'b0;

      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < 256; i++) pre_a[i] = '0;
         expq.delete();
         if (vecs[v].n0 != 0) begin pre_a[vecs[v].c0] = vecs[v].n0; expq.push_back({vecs[v].c0, vecs[v].n0}); end
         if (vecs[v].n1 != 0) begin pre_a[vecs[v].c1] = vecs[v].n1; expq.push_back({vecs[v].c1, vecs[v].n1}); end
         if (vecs[v].n2 != 0) begin pre_a[vecs[v].c2] = vecs[v].n2; expq.push_back({vecs[v].c2, vecs[v].n2}); end
         load_a = 1'b1;
         @(posedge clk);
         #1;
         load_a = 1'b0;
         stall  = vecs[v].stall;
         got_a.delete();
         snap = stab_viol;
         kick(1'b0, vecs[v].total);
         wait_done(1'b0, cyc);
         chk($sformatf("v%0d_cycles", v), 64'(cyc), 64'(vecs[v].exp_cyc));
         chk($sformatf("v%0d_nz", v), nz_a, 9'(vecs[v].exp_nz));
         chk($sformatf("v%0d_sum", v), sum_a, vecs[v].exp_sum);
         chk($sformatf("v%0d_mismatch", v), mm_a, vecs[v].exp_mm);
         chk($sformatf("v%0d_busy", v), busy_a, 1'b0);
         chk($sformatf("v%0d_npairs", v), 64'(got_a.size()), 64'(expq.size()));
         for (int k = 0; k < expq.size() && k < got_a.size(); k++) begin
            chk($sformatf("v%0d_pair%0d", v, k), got_a[k], expq[k]);
            chk($sformatf("v%0d_cleared%0d", v, k), mem_a[expq[k][39:32]], 32'd0);
         end
         chk($sformatf("v%0d_stable", v), 64'(stab_viol), 64'(snap));
      end
      stall = 0;
      chk("proto_a_rd_wr_overlap", 64'(proto_a), 64'd0);

      // Non-clearing instance, random ack latency, start pulsed mid-sweep.
      for (int i = 0; i < 256; i++) pre_b[i] = '0;
      pre_b[8'h00] = 32'd10; pre_b[8'h41] = 32'd3; pre_b[8'hFF] = 32'd1;
      load_b = 1'b1;
      @(posedge clk);
      #1;
      load_b = 1'b0;
      got_b.delete();
      kick(1'b1, 32'd14);
      repeat (100) @(posedge clk);
      #1;
      chk("b_busy_mid", busy_b, 1'b1);
      kick(1'b1, 32'd99);
      chk("b_busy_after_start", busy_b, 1'b1);
      wait_done(1'b1, cyc);
      chk("b_nz", nz_b, 9'd3);
      chk("b_sum", sum_b, 32'd14);
      chk("b_mismatch", mm_b, 1'b0);
      chk("b_npairs", 64'(got_b.size()), 64'd3);
      if (got_b.size() == 3) begin
         chk("b_pair0", got_b[0], {8'h00, 32'd10});
         chk("b_pair1", got_b[1], {8'h41, 32'd3});
         chk("b_pair2", got_b[2], {8'hFF, 32'd1});
      end
      chk("b_mem_kept", {mem_b[8'h00], mem_b[8'h41], mem_b[8'hFF]}, {32'd10, 32'd3, 32'd1});
      chk("b_protocol", 64'(proto_b), 64'd0);

      // Reset while holding the 0x41 pair, then a fresh sweep.
      for (int i = 0; i < 256; i++) pre_a[i] = '0;
      pre_a[8'h00] = 32'd10; pre_a[8'h41] = 32'd3; pre_a[8'hFF] = 32'd1;
      load_a = 1'b1;
      @(posedge clk);
      #1;
      load_a  = 1'b0;
      block41 = 1'b1;
      got_a.delete();
      kick(1'b0, 32'd14);
      cyc = 0;
      while (!(valid_a && char_a == 8'h41) && cyc < 2000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("r_reached_41", {valid_a, char_a}, {1'b1, 8'h41});
      chk("r_first_pair", 64'(got_a.size()), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      block41 = 1'b0;
      chk("r_outputs_zero",
          {valid_a, char_a, count_a, nz_a, sum_a, busy_a, done_a, mm_a,
           sram_a.rd_en, sram_a.wr_en, sram_a.addr},
          '0);
      chk("r_mem41_cleared", mem_a[8'h41], 32'd0);
      chk("r_memFF_kept", mem_a[8'hFF], 32'd1);
      kick(1'b0, 32'd1);
      chk("r_restart_addr", {sram_a.rd_en, sram_a.addr}, {1'b1, 8'h00});
      wait_done(1'b0, cyc);
      chk("r_nz", nz_a, 9'd1);
      chk("r_sum", sum_a, 32'd1);
      chk("r_mismatch", mm_a, 1'b0);
      chk("r_memFF_cleared", mem_a[8'hFF], 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
